register_bank_sb: RTL and testbench
===================================

Name: register_bank_sb

Overview:
- Parametrised, clocked successor to the combinational 16x32 register bank.
- Provides one write port, two read ports with registered outputs, and a per-register busy scoreboard with reserve/release semantics.
- Sits between decode (reads operands, reserves destinations) and writeback (writes results, releasing the reservation).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 4, address width; register count NUM_REGS = 2**ADDR_W.
- ZERO_REG, 0, when 1 register 0 reads as zero, ignores writes and is never busy.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- we  in  1  write enable.
- dest  in  ADDR_W  write address.
- Din  in  DATA_W  write data.
- rd_en  in  1  read request for both read ports.
- srcadd1  in  ADDR_W  read address, port 1.
- srcadd2  in  ADDR_W  read address, port 2.
- src1  out  DATA_W  registered read data, port 1.
- src2  out  DATA_W  registered read data, port 2.
- src_valid  out  1  src1/src2/busy1/busy2 valid this cycle.
- busy1  out  1  registered busy flag of srcadd1 at read time.
- busy2  out  1  registered busy flag of srcadd2 at read time.
- rsv_en  in  1  reserve request.
- rsv_addr  in  ADDR_W  register to mark busy.
- busy_cnt  out  ADDR_W+1  number of busy registers (registered).

Behaviour:
- Reset (async, rst=1):
  - All registers = 0; all busy bits = 0.
  - src1 = src2 = 0; src_valid = busy1 = busy2 = 0; busy_cnt = 0.
  - Takes effect immediately and holds while rst=1. Any operation in flight is dropped: a read issued the cycle before reset produces no src_valid.
- Write: on a rising edge with we=1, reg[dest] <= Din and busy[dest] <= 0. With ZERO_REG=1 and dest=0 there is no effect.
- Reserve: on a rising edge with rsv_en=1, busy[rsv_addr] <= 1. With ZERO_REG=1 and rsv_addr=0 it is ignored.
- Same-edge we and rsv_en to the same address: data is written and busy ends at 1 (reserve wins, since a new producer is now pending).
- Reserving an already-busy register: busy stays 1; busy_cnt is unchanged.
- Writing a non-busy register: legal; busy stays 0.
- Read latency is 1 cycle:
  - rd_en sampled at edge N gives src1/src2/busy1/busy2 valid with src_valid=1 after edge N+1... more precisely, registered at edge N and visible during cycle N+1.
  - Read data is the pre-edge register contents.
  - busy1/busy2 are the pre-edge busy bits.
- src_valid is high for exactly one cycle per rd_en cycle. Back-to-back rd_en gives back-to-back valid.
- When rd_en=0, src1/src2/busy1/busy2 hold their last values and src_valid=0.
- srcadd1 = srcadd2 is legal; both ports return identical values.
- Read of an address written on the same edge returns the old data and the old busy bit (no bypass). The optional feature changes this.
- busy_cnt equals the population count of the busy vector after each edge. Its range is 0..NUM_REGS with no wrap: ADDR_W+1 bits hold NUM_REGS.
- ZERO_REG=1: src for address 0 is always 0 and busy is always 0.

Optional Feature:
- Macro: REGBANK_BYPASS_EN.
- Defined: a read on the same edge as a write to a matching address (we=1, dest=srcaddX, and not zero-reg suppressed) returns Din on that port. Its busy flag reflects the post-write value: 0, unless rsv_en to the same address on that edge, in which case 1.
- Undefined: the read returns old contents and old busy as above.
- Bypass adds one mux per port; latency stays 1 cycle.

Test Plan:
1. Reset then read: rst pulse, then rd_en=1, srcadd1=3, srcadd2=15 -> next cycle src_valid=1, src1=0, src2=0, busy1=busy2=0, busy_cnt=0.
2. Write then read: we, dest=1, Din=1; next cycle we, dest=4, Din=19; then rd_en, srcadd1=1, srcadd2=4 -> src1=1, src2=19 one cycle later, src_valid high for exactly one cycle.
3. Scoreboard: rsv_en, rsv_addr=5 -> busy_cnt=1. Read 5 -> busy1=1. Write dest=5, Din=0xDEADBEEF -> busy_cnt=0. Read 5 -> src1=0xDEADBEEF, busy1=0.
4. Simultaneous ops: reg 7 holds 0x11; same edge we dest=7 Din=0xAA, rsv_en rsv_addr=7, rd_en srcadd1=7 -> without bypass src1=0x11, busy1=0; with REGBANK_BYPASS_EN src1=0xAA, busy1=1. In both cases reg7=0xAA afterwards and busy_cnt=1.
5. Full/zero reg: reserve all 16 addresses over 16 cycles (ZERO_REG=0) -> busy_cnt=16, no wrap. With ZERO_REG=1: write reg0=0x55 and reserve reg0 -> read src1=0, busy1=0, busy_cnt unchanged.
6. Reset mid-operation: rd_en at edge N with rst asserted asynchronously before edge N+1 -> src_valid=0, all outputs 0 immediately; after deassertion, a read of a previously written register returns 0.

Source files
------------

// File: rtl/register_bank_sb.sv
// register_bank_sb: clocked register bank with one write port, two registered
// read ports and a per-register busy scoreboard (reserve at decode, release at
// writeback).
// Optional feature macro: REGBANK_BYPASS_EN -- when defined, a read that hits
// the register being written on the same edge returns the write data and the
// post-edge busy bit instead of the old contents.

// Per-port read mux: selects the pre-edge register/busy value, optionally the
// same-edge write, and forces register 0 to zero/not-busy when ZERO_REG=1.
module register_bank_sb_rdport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic [ADDR_W-1:0]                   addr,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]  regs,
    input  logic [(1<<ADDR_W)-1:0]              busy,
    input  logic [(1<<ADDR_W)-1:0]              busy_nxt,
    input  logic                                we_eff,
    input  logic [ADDR_W-1:0]                   dest,
    input  logic [DATA_W-1:0]                   din,
    output logic [DATA_W-1:0]                   data,
    output logic                                bsy
);

`ifndef REGBANK_BYPASS_EN
    // Only consumed by the bypass path.
    logic unused_byp;
    assign unused_byp = ^{busy_nxt, we_eff, dest, din};
`endif

    // Operand select for this port.
    always_comb begin
        data = regs[addr];
        bsy  = busy[addr];
`ifdef REGBANK_BYPASS_EN
        if (we_eff && (dest == addr)) begin
            data = din;
            bsy  = busy_nxt[addr];
        end
`endif
        if ((ZERO_REG != 0) && (addr == '0)) begin
            data = '0;
            bsy  = 1'b0;
        end
    end

endmodule

module register_bank_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] dest,
    input  logic [DATA_W-1:0] Din,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] srcadd1,
    input  logic [ADDR_W-1:0] srcadd2,
    output logic [DATA_W-1:0] src1,
    output logic [DATA_W-1:0] src2,
    output logic              src_valid,
    output logic              busy1,
    output logic              busy2,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int NPORTS   = 2;
    localparam int STAGES   = 1;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0]             busy;
    logic [NUM_REGS-1:0]             busy_nxt;
    logic [ADDR_W:0]                 cnt_nxt;
    logic                            we_eff;
    logic                            rsv_eff;
    logic [STAGES:0]                 vld_pipe;

    logic [NPORTS-1:0][ADDR_W-1:0]   rd_addr;
    logic [NPORTS-1:0][DATA_W-1:0]   rd_data;
    logic [NPORTS-1:0]               rd_busy;

    // Register 0 swallows writes and reserves when hardwired to zero.
    assign we_eff  = we     && !((ZERO_REG != 0) && (dest     == '0));
    assign rsv_eff = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

    // Next busy vector: writeback releases, then reserve sets (a new producer
    // issued on the same edge keeps the register pending).
    always_comb begin
        busy_nxt = busy;
        if (we_eff)  busy_nxt[dest]     = 1'b0;
        if (rsv_eff) busy_nxt[rsv_addr] = 1'b1;
    end

    // Population count of the next busy vector; ADDR_W+1 bits hold NUM_REGS.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++)
            cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end

    assign rd_addr[0] = srcadd1;
    assign rd_addr[1] = srcadd2;

    genvar p;
    generate
        for (p = 0; p < NPORTS; p++) begin : g_rd
            register_bank_sb_rdport #(
                .DATA_W  (DATA_W),
                .ADDR_W  (ADDR_W),
                .ZERO_REG(ZERO_REG)
            ) u_rdport (
                .addr    (rd_addr[p]),
                .regs    (regs),
                .busy    (busy),
                .busy_nxt(busy_nxt),
                .we_eff  (we_eff),
                .dest    (dest),
                .din     (Din),
                .data    (rd_data[p]),
                .bsy     (rd_busy[p])
            );
        end
    endgenerate

    // Register file and scoreboard state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs     <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (we_eff) regs[dest] <= Din;
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // Read valid pipeline: one stage from rd_en to src_valid.
    assign vld_pipe[0] = rd_en;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe[STAGES:1] <= '0;
        else     vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end
    assign src_valid = vld_pipe[STAGES];

    // Registered read data and busy flags; hold when no read is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src1  <= '0;
            src2  <= '0;
            busy1 <= 1'b0;
            busy2 <= 1'b0;
        end else if (rd_en) begin
            src1  <= rd_data[0];
            src2  <= rd_data[1];
            busy1 <= rd_busy[0];
            busy2 <= rd_busy[1];
        end
    end

endmodule

// File: tb/tb_register_bank_sb.sv
// Directed testbench for register_bank_sb. Two instances share stimulus: one
// with ZERO_REG=0 (main checks) and one with ZERO_REG=1 (zero-register checks).
module tb_register_bank_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              we;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] Din;
    logic              rd_en;
    logic [ADDR_W-1:0] srcadd1, srcadd2;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;

    logic [DATA_W-1:0] src1, src2, zsrc1, zsrc2;
    logic              src_valid, busy1, busy2, zsrc_valid, zbusy1, zbusy2;
    logic [ADDR_W:0]   busy_cnt, zbusy_cnt;

    int checks   = 0;
    int failures = 0;

`ifdef REGBANK_BYPASS_EN
    localparam logic [31:0] EXP_T4_SRC  = 32'hAA;
    localparam logic        EXP_T4_BUSY = 1'b1;
`else
    localparam logic [31:0] EXP_T4_SRC  = 32'h11;
    localparam logic        EXP_T4_BUSY = 1'b0;
`endif

    register_bank_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(0)) dut (
        .clk(clk), .rst(rst), .we(we), .dest(dest), .Din(Din),
        .rd_en(rd_en), .srcadd1(srcadd1), .srcadd2(srcadd2),
        .src1(src1), .src2(src2), .src_valid(src_valid),
        .busy1(busy1), .busy2(busy2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(busy_cnt)
    );

    register_bank_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dutz (
        .clk(clk), .rst(rst), .we(we), .dest(dest), .Din(Din),
        .rd_en(rd_en), .srcadd1(srcadd1), .srcadd2(srcadd2),
        .src1(zsrc1), .src2(zsrc2), .src_valid(zsrc_valid),
        .busy1(zbusy1), .busy2(zbusy2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(zbusy_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 0; rd_en = 0; rsv_en = 0;
    endtask

    initial begin
        rst = 1; idle(); dest = 0; Din = 0; srcadd1 = 0; srcadd2 = 0; rsv_addr = 0;
        step(); step();
        chk("rst_valid", src_valid, 0);
        chk("rst_src1",  src1, 0);
        chk("rst_cnt",   busy_cnt, 0);
        rst = 0;

        // 1: read after reset
        rd_en = 1; srcadd1 = 3; srcadd2 = 15;
        step();
        chk("t1_valid", src_valid, 1);
        chk("t1_src1",  src1, 0);
        chk("t1_src2",  src2, 0);
        chk("t1_busy1", busy1, 0);
        chk("t1_busy2", busy2, 0);
        chk("t1_cnt",   busy_cnt, 0);
        idle();
        step();
        chk("t1_valid_drop", src_valid, 0);

        // 2: write then read
        we = 1; dest = 1; Din = 1;
        step();
        dest = 4; Din = 19;
        step();
        idle(); rd_en = 1; srcadd1 = 1; srcadd2 = 4;
        step();
        chk("t2_valid", src_valid, 1);
        chk("t2_src1",  src1, 1);
        chk("t2_src2",  src2, 19);
        idle();
        step();
        chk("t2_valid_once", src_valid, 0);
        chk("t2_hold_src2",  src2, 19);

        // 3: scoreboard reserve / release
        rsv_en = 1; rsv_addr = 5;
        step();
        idle();
        chk("t3_cnt_rsv", busy_cnt, 1);
        rd_en = 1; srcadd1 = 5;
        step();
        chk("t3_busy1_set", busy1, 1);
        idle(); we = 1; dest = 5; Din = 32'hDEADBEEF;
        step();
        chk("t3_cnt_rel", busy_cnt, 0);
        idle(); rd_en = 1; srcadd1 = 5;
        step();
        chk("t3_src1",      src1, 32'hDEADBEEF);
        chk("t3_busy1_clr", busy1, 0);
        idle();

        // 4: same-edge write, reserve and read of reg 7
        we = 1; dest = 7; Din = 32'h11;
        step();
        Din = 32'hAA; rsv_en = 1; rsv_addr = 7; rd_en = 1; srcadd1 = 7; srcadd2 = 7;
        step();
        chk("t4_src1",  src1, EXP_T4_SRC);
        chk("t4_src2",  src2, EXP_T4_SRC);
        chk("t4_busy1", busy1, EXP_T4_BUSY);
        chk("t4_cnt",   busy_cnt, 1);
        idle(); rd_en = 1; srcadd1 = 7;
        step();
        chk("t4_after_src1",  src1, 32'hAA);
        chk("t4_after_busy1", busy1, 1);
        idle();

        // 5: reserve every register (reg 7 already busy), no wrap
        for (int i = 0; i < 16; i++) begin
            rsv_en = 1; rsv_addr = i[ADDR_W-1:0];
            step();
        end
        idle();
        chk("t5_cnt_full",  busy_cnt, 16);
        chk("t5_zcnt_full", zbusy_cnt, 15);
        // write + reserve register 0 on both instances
        we = 1; dest = 0; Din = 32'h55; rsv_en = 1; rsv_addr = 0;
        step();
        idle(); rd_en = 1; srcadd1 = 0; srcadd2 = 0;
        step();
        chk("t5_src1_r0",   src1, 32'h55);
        chk("t5_busy1_r0",  busy1, 1);
        chk("t5_cnt_r0",    busy_cnt, 16);
        chk("t5_zsrc1_r0",  zsrc1, 0);
        chk("t5_zsrc2_r0",  zsrc2, 0);
        chk("t5_zbusy1_r0", zbusy1, 0);
        chk("t5_zcnt_r0",   zbusy_cnt, 15);
        idle();

        // 6: asynchronous reset while a read is in flight
        rd_en = 1; srcadd1 = 1;
        step();
        chk("t6_pre_valid", src_valid, 1);
        #2 rst = 1;
        #1;
        chk("t6_rst_valid", src_valid, 0);
        chk("t6_rst_src1",  src1, 0);
        chk("t6_rst_cnt",   busy_cnt, 0);
        chk("t6_rst_zcnt",  zbusy_cnt, 0);
        step();
        chk("t6_hold_valid", src_valid, 0);
        rst = 0; rd_en = 1; srcadd1 = 1; srcadd2 = 5;
        step();
        chk("t6_valid", src_valid, 1);
        chk("t6_src1",  src1, 0);
        chk("t6_src2",  src2, 0);
        chk("t6_busy1", busy1, 0);
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
